// File: rtl/cpu_types_pkg.sv
// rtl/cpu_types_pkg.sv - shared CPU/RAM types and memory arbiter definitions
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        FREE,
        BUSY,
        ACCESS,
        ERROR
    } ramstate_t;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        RETRY
    } arb_state_t;

    typedef struct packed {
        logic isdata;
        logic core;
    } arb_src_t;

    localparam word_t ERR_WORD_DEF  = 32'hBAD1BAD1;
    localparam int    MAX_RETRY_DEF = 3;

endpackage

// File: rtl/memory_arbiter_if.sv
// rtl/memory_arbiter_if.sv - cache-side request bus and RAM-side port of the memory arbiter
interface memory_arbiter_if #(
    parameter int NCORES = 2
);
    import cpu_types_pkg::*;

    logic [NCORES-1:0]  iREN;
    word_t [NCORES-1:0] iaddr;
    logic [NCORES-1:0]  dREN;
    logic [NCORES-1:0]  dWEN;
    word_t [NCORES-1:0] daddr;
    word_t [NCORES-1:0] dstore;
    logic [NCORES-1:0]  iwait;
    logic [NCORES-1:0]  dwait;
    word_t [NCORES-1:0] iload;
    word_t [NCORES-1:0] dload;
    logic               ramREN;
    logic               ramWEN;
    word_t              ramaddr;
    word_t              ramstore;
    word_t              ramload;
    ramstate_t          ramstate;
    logic               err;

    modport slave (
        input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        output iwait, dwait, iload, dload, ramREN, ramWEN, ramaddr, ramstore, err
    );

    modport master (
        output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        input  iwait, dwait, iload, dload, ramREN, ramWEN, ramaddr, ramstore, err
    );

endinterface

// File: rtl/memory_arbiter_rr_picker.sv
// rtl/memory_arbiter_rr_picker.sv - round-robin picker: first requester at or after ptr
module rr_picker #(
    parameter int NCORES = 2,
    parameter int PW     = (NCORES > 1) ? $clog2(NCORES) : 1
) (
    input  logic [NCORES-1:0] req_i,
    input  logic [PW-1:0]     ptr_i,
    output logic [NCORES-1:0] grant_o,
    output logic              valid_o
);

    logic [PW-1:0] idx;

    always_comb begin
        grant_o = '0;
        valid_o = 1'b0;
        idx     = ptr_i;
        for (int k = 0; k < NCORES; k++) begin
            idx = PW'((int'(ptr_i) + k) % NCORES);
            if (!valid_o && req_i[idx]) begin
                grant_o[idx] = 1'b1;
                valid_o      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/memory_arbiter.sv
// rtl/memory_arbiter.sv - shares one RAM port between the i/d caches of two cores
module memory_arbiter
    import cpu_types_pkg::*;
#(
    parameter int    NCORES    = 2,
    parameter int    MAX_RETRY = MAX_RETRY_DEF,
    parameter word_t ERR_WORD  = ERR_WORD_DEF
) (
    input logic             CLK,
    input logic             RST,
    memory_arbiter_if.slave bus
);

    localparam int            RW   = $clog2(MAX_RETRY + 1);
    localparam logic [RW-1:0] RMAX = RW'(MAX_RETRY);

    arb_state_t         state_q;
    arb_src_t           src_q;
    word_t              addr_q;
    word_t              store_q;
    logic               rw_q;
    logic               dptr_q;
    logic               iptr_q;
    logic               err_q;
    logic [RW-1:0]      retry_q;
    word_t [NCORES-1:0] iload_q;
    word_t [NCORES-1:0] dload_q;

    logic [NCORES-1:0] dreq;
    logic [NCORES-1:0] dgrant;
    logic [NCORES-1:0] igrant;
    logic              dvalid;
    logic              ivalid;
    logic              pick_core;
    logic              own_req;
    logic              forced;
    logic              complete;
    logic              deliver;
    word_t             ld_val;

    assign dreq = bus.dREN | bus.dWEN;

    rr_picker #(.NCORES(NCORES)) u_dpick (
        .req_i   (dreq),
        .ptr_i   (dptr_q),
        .grant_o (dgrant),
        .valid_o (dvalid)
    );

    rr_picker #(.NCORES(NCORES)) u_ipick (
        .req_i   (bus.iREN),
        .ptr_i   (iptr_q),
        .grant_o (igrant),
        .valid_o (ivalid)
    );

    // Data class wins outright; the grant of the winning class names the core.
    assign pick_core = dvalid ? |(dgrant >> 1) : |(igrant >> 1);

    // A withdrawn requester still lets the RAM access finish but gets no wait-low pulse.
    assign own_req  = src_q.isdata ? dreq[src_q.core] : bus.iREN[src_q.core];
    assign forced   = (state_q == RETRY) && (retry_q >= RMAX);
    assign complete = ((state_q == ISSUE) && (bus.ramstate == ACCESS)) || forced;
    assign deliver  = complete && own_req;
    assign ld_val   = forced ? ERR_WORD : bus.ramload;

    always_comb begin
        bus.iwait = '1;
        bus.dwait = '1;
        bus.iload = iload_q;
        bus.dload = dload_q;
        if (deliver) begin
            if (src_q.isdata) begin
                bus.dwait[src_q.core] = 1'b0;
                if (!rw_q) begin
                    bus.dload[src_q.core] = ld_val;
                end
            end else begin
                bus.iwait[src_q.core] = 1'b0;
                bus.iload[src_q.core] = ld_val;
            end
        end
    end

    assign bus.ramREN   = (state_q == ISSUE) && !rw_q;
    assign bus.ramWEN   = (state_q == ISSUE) && rw_q;
    assign bus.ramaddr  = addr_q;
    assign bus.ramstore = store_q;
    assign bus.err      = err_q;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
            src_q   <= '0;
            addr_q  <= '0;
            store_q <= '0;
            rw_q    <= 1'b0;
            dptr_q  <= 1'b0;
            iptr_q  <= 1'b0;
            err_q   <= 1'b0;
            retry_q <= '0;
            iload_q <= '0;
            dload_q <= '0;
        end else begin
            if (complete) begin
                state_q <= IDLE;
                retry_q <= '0;
                if (src_q.isdata) begin
                    dptr_q <= ~src_q.core;
                end else begin
                    iptr_q <= ~src_q.core;
                end
                if (forced) begin
                    err_q <= 1'b1;
                end
            end else begin
                case (state_q)
                    IDLE: begin
                        if (dvalid || ivalid) begin
                            src_q   <= arb_src_t'{isdata: dvalid, core: pick_core};
                            state_q <= ISSUE;
                            if (dvalid) begin
                                addr_q  <= bus.daddr[pick_core];
                                store_q <= bus.dstore[pick_core];
                                rw_q    <= bus.dWEN[pick_core];
                            end else begin
                                addr_q  <= bus.iaddr[pick_core];
                                store_q <= '0;
                                rw_q    <= 1'b0;
                            end
                        end
                    end
                    ISSUE: begin
                        if (bus.ramstate == ERROR) begin
                            retry_q <= retry_q + RW'(1);
                            state_q <= RETRY;
                        end
                    end
                    RETRY:   state_q <= ISSUE;
                    default: state_q <= IDLE;
                endcase
            end

            if (deliver && !(src_q.isdata && rw_q)) begin
                if (src_q.isdata) begin
                    dload_q[src_q.core] <= ld_val;
                end else begin
                    iload_q[src_q.core] <= ld_val;
                end
            end
        end
    end

endmodule
